wvb_reader: RTL

- Drains completed waveforms from the waveform buffer, the consumer side of its header-FIFO / sample-RAM read interface.
- Pops one header, reads that event's samples, and serialises header plus samples into a 16-bit valid/ready word stream for the XDOM readout path.
- Pulses rddone after each event so the buffer frees the space.

---
 rtl/wvb_reader_if.sv | 29 ++
 rtl/wvb_reader.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/wvb_reader_if.sv
// Read-side bundle between the waveform buffer and its reader: header FIFO,
// sample RAM and the 16-bit output word stream.
interface wvb_reader_if #(
    parameter int unsigned P_DATA_WIDTH = 22,
    parameter int unsigned P_HDR_WIDTH  = 80
);
    logic [P_HDR_WIDTH-1:0]  hdr_data;
    logic                    hdr_empty;
    logic                    hdr_rdreq;
    logic [P_DATA_WIDTH-1:0] wvb_data;
    logic                    wvb_rdreq;
    logic                    wvb_rddone;
    logic [15:0]             dout;
    logic                    dout_valid;
    logic                    dout_ready;
    logic                    dout_last;

    // master: the reader, which issues requests and sources the output stream.
    modport master (
        input  hdr_data, hdr_empty, wvb_data, dout_ready,
        output hdr_rdreq, wvb_rdreq, wvb_rddone, dout, dout_valid, dout_last
    );

    // slave: the buffer plus the downstream sink.
    modport slave (
        output hdr_data, hdr_empty, wvb_data, dout_ready,
        input  hdr_rdreq, wvb_rdreq, wvb_rddone, dout, dout_valid, dout_last
    );
endinterface

// File: rtl/wvb_reader.sv
// Waveform buffer reader: pops one header, reads that event's samples and
// serialises header plus samples onto a 16-bit valid/ready word stream.
module wvb_reader #(
    parameter int unsigned P_DATA_WIDTH = 22,
    parameter int unsigned P_ADR_WIDTH  = 12,
    parameter int unsigned P_HDR_WIDTH  = 80,
    parameter int unsigned P_LTC_WIDTH  = 48
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    wvb_reader_if.master bus,
    output logic         busy,
    output logic [15:0]  evt_cnt,
    output logic         fmt_err
);
    localparam int unsigned CntWidth = P_ADR_WIDTH + 1;
    localparam int unsigned StopLsb  = 8;
    localparam int unsigned StartLsb = StopLsb + P_ADR_WIDTH;
    localparam int unsigned LtcLsb   = P_HDR_WIDTH - P_LTC_WIDTH;
    localparam int unsigned EoeBit   = P_DATA_WIDTH - 1;
    localparam int unsigned TotBit   = P_DATA_WIDTH - 2;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StFetch,
        StLatch,
        StSHi,
        StSLo,
        StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [2:0]              word_q, word_d;
    logic [P_LTC_WIDTH-1:0]  ltc_q, ltc_d;
    logic [P_ADR_WIDTH-1:0]  start_q, start_d;
    logic [1:0]              trig_q, trig_d;
    logic [P_ADR_WIDTH-1:0]  nsamp_q, nsamp_d;
    logic [CntWidth-1:0]     remain_q, remain_d;
    logic [P_DATA_WIDTH-1:0] samp_q, samp_d;
    logic [15:0]             evt_cnt_q, evt_cnt_d;
    logic                    fmt_err_q, fmt_err_d;

    logic [P_ADR_WIDTH-1:0]  hdr_start;
    logic [P_ADR_WIDTH-1:0]  hdr_stop;
    logic [P_ADR_WIDTH-1:0]  hdr_nsamp;
    logic                    last_samp;
    logic                    unused_hdr;

    assign hdr_start = bus.hdr_data[StartLsb +: P_ADR_WIDTH];
    assign hdr_stop  = bus.hdr_data[StopLsb +: P_ADR_WIDTH];
    // Modulo arithmetic: a zero result means a full-buffer event.
    assign hdr_nsamp = hdr_stop - hdr_start + P_ADR_WIDTH'(1);
    assign last_samp = (remain_q == CntWidth'(1));
    assign unused_hdr = ^bus.hdr_data[StopLsb-1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            word_q    <= '0;
            ltc_q     <= '0;
            start_q   <= '0;
            trig_q    <= '0;
            nsamp_q   <= '0;
            remain_q  <= '0;
            samp_q    <= '0;
            evt_cnt_q <= '0;
            fmt_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            ltc_q     <= ltc_d;
            start_q   <= start_d;
            trig_q    <= trig_d;
            nsamp_q   <= nsamp_d;
            remain_q  <= remain_d;
            samp_q    <= samp_d;
            evt_cnt_q <= evt_cnt_d;
            fmt_err_q <= fmt_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        word_d         = word_q;
        ltc_d          = ltc_q;
        start_d        = start_q;
        trig_d         = trig_q;
        nsamp_d        = nsamp_q;
        remain_d       = remain_q;
        samp_d         = samp_q;
        evt_cnt_d      = evt_cnt_q;
        fmt_err_d      = fmt_err_q;
        bus.hdr_rdreq  = 1'b0;
        bus.wvb_rdreq  = 1'b0;
        bus.wvb_rddone = 1'b0;
        bus.dout       = '0;
        bus.dout_valid = 1'b0;
        bus.dout_last  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Gate with rst so no pop leaks out while reset is held.
                if (en && !bus.hdr_empty && !rst) begin
                    bus.hdr_rdreq = 1'b1;
                    ltc_d         = bus.hdr_data[LtcLsb +: P_LTC_WIDTH];
                    start_d       = hdr_start;
                    trig_d        = bus.hdr_data[1:0];
                    nsamp_d       = hdr_nsamp;
                    remain_d      = (hdr_nsamp == '0) ? {1'b1, {P_ADR_WIDTH{1'b0}}}
                                                      : {1'b0, hdr_nsamp};
                    word_d        = '0;
                    state_d       = StHdr;
                end
            end
            StHdr: begin
                bus.dout_valid = 1'b1;
                case (word_q)
                    3'd0:    bus.dout = {4'hA, nsamp_q};
                    3'd1:    bus.dout = ltc_q[P_LTC_WIDTH-1 -: 16];
                    3'd2:    bus.dout = ltc_q[P_LTC_WIDTH-17 -: 16];
                    3'd3:    bus.dout = ltc_q[15:0];
                    default: bus.dout = {start_q, 2'b00, trig_q};
                endcase
                if (bus.dout_ready) begin
                    if (word_q == 3'd4) begin
                        state_d = StFetch;
                    end else begin
                        word_d = word_q + 3'd1;
                    end
                end
            end
            StFetch: begin
                bus.wvb_rdreq = 1'b1;
                state_d       = StLatch;
            end
            StLatch: begin
                samp_d = bus.wvb_data;
                // The header length wins; an eoe flag in the wrong place only flags it.
                if (bus.wvb_data[EoeBit] != last_samp) begin
                    fmt_err_d = 1'b1;
                end
                state_d = StSHi;
            end
            StSHi: begin
                bus.dout_valid = 1'b1;
                bus.dout       = {2'b00, samp_q[EoeBit], samp_q[TotBit], samp_q[11:0]};
                if (bus.dout_ready) begin
                    state_d = StSLo;
                end
            end
            StSLo: begin
                bus.dout_valid = 1'b1;
                bus.dout       = {8'h00, samp_q[19:12]};
                bus.dout_last  = last_samp;
                if (bus.dout_ready) begin
                    remain_d = remain_q - CntWidth'(1);
                    state_d  = last_samp ? StDone : StFetch;
                end
            end
            StDone: begin
                bus.wvb_rddone = 1'b1;
                evt_cnt_d      = evt_cnt_q + 16'd1;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy    = (state_q != StIdle);
    assign evt_cnt = evt_cnt_q;
    assign fmt_err = fmt_err_q;

    // Word must hold through a stall; sample reads are never back to back.
    assert property (@(posedge clk) disable iff (rst)
        bus.dout_valid && !bus.dout_ready |=>
            bus.dout_valid && $stable(bus.dout) && $stable(bus.dout_last));
    assert property (@(posedge clk) disable iff (rst) bus.wvb_rdreq |=> !bus.wvb_rdreq);
endmodule
